// File: rtl/ifc_burst_xfer.sv
// ifc_burst_xfer -- downstream data stage of the IFC burst timer.
//
// Moves one DATA_W word per timer beat between the IFC AD bus and a local
// synchronous register file. Read bursts prefetch the first word and drive it
// on the AD bus; write bursts capture the AD bus into the register file.
// Completion, timeout and protocol errors are reported as one-cycle pulses.
//
// Optional build macro: IFC_BEAT_CHECK_EN
//   When defined, every beat cross-checks the timer's beat_cnt against the
//   internal beat counter and aborts the burst on a mismatch. When undefined,
//   beat_cnt is present but ignored.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid/rw/addr burst start pulse, direction (1 = read) and start address
//   beat_strobe       per-beat strobe from the timer (rw_burst_flag)
//   beat_cnt          timer beat count
//   ifc_ad_in         AD bus input (captured on write beats)
//   ifc_ad_out/oe     AD bus drive value and output enable (read bursts)
//   rd_addr/rd_data   register file read port, data valid 1 cycle after address
//   wr_en/addr/data   register file write port
//   busy, done, err   burst in progress, success pulse, error pulse
module ifc_burst_xfer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BURST_LEN = 3,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              beat_strobe,
  input  logic [7:0]        beat_cnt,
  input  logic [DATA_W-1:0] ifc_ad_in,
  output logic [DATA_W-1:0] ifc_ad_out,
  output logic              ifc_ad_oe,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PREFETCH, BEAT, FINISH} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [7:0]        beat_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              pf_q;      // second prefetch cycle
  logic              rdp1_q;    // read refill pipeline: rd_addr issued
  logic              rdp2_q;    // read refill pipeline: rd_data valid now
  logic [DATA_W-1:0] ad_out_q;
  logic              oe_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        beat_d;
  logic              tmo_hit;
  logic              cnt_ok;
  logic              last_beat;
  logic              abort_d;

`ifdef IFC_BEAT_CHECK_EN
  // The timer updates cnt in the same cycle as the strobe.
  assign cnt_ok = (beat_cnt == beat_d);
`else
  logic unused_beat_cnt;
  assign unused_beat_cnt = ^beat_cnt;
  assign cnt_ok          = 1'b1;
`endif

  always_comb begin
    addr_d    = addr_q + 1'b1;
    beat_d    = beat_q + 8'd1;
    tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));
    last_beat = (beat_d == 8'(BURST_LEN));
    abort_d   = 1'b0;
    case (state_q)
      PREFETCH: abort_d = beat_strobe || tmo_hit;
      BEAT:     abort_d = beat_strobe ? !cnt_ok : tmo_hit;
      default:  abort_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      beat_q    <= '0;
      tmo_q     <= '0;
      pf_q      <= 1'b0;
      rdp1_q    <= 1'b0;
      rdp2_q    <= 1'b0;
      ad_out_q  <= '0;
      oe_q      <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_en_q <= 1'b0;
      rdp1_q  <= 1'b0;
      if (abort_d) begin
        // Timeout, strobe during prefetch, or beat count mismatch: no write.
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
        oe_q    <= 1'b0;
        pf_q    <= 1'b0;
        rdp2_q  <= 1'b0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (cmd_valid) begin
              addr_q <= cmd_addr;
              rw_q   <= cmd_rw;
              beat_q <= '0;
              tmo_q  <= '0;
              pf_q   <= 1'b0;
              busy_q <= 1'b1;
              if (cmd_rw) begin
                rd_addr_q <= cmd_addr;
                state_q   <= PREFETCH;
              end else begin
                state_q <= BEAT;
              end
            end
          end
          PREFETCH: begin
            tmo_q <= tmo_q + 1'b1;
            if (pf_q) begin
              ad_out_q <= rd_data;
              oe_q     <= 1'b1;
              pf_q     <= 1'b0;
              state_q  <= BEAT;
            end else begin
              pf_q <= 1'b1;
            end
          end
          BEAT: begin
            // Refill of the AD word lands two cycles after a read strobe.
            rdp2_q <= rdp1_q;
            if (rdp2_q) ad_out_q <= rd_data;
            if (beat_strobe) begin
              addr_q <= addr_d;
              beat_q <= beat_d;
              tmo_q  <= '0;
              if (!rw_q) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= ifc_ad_in;
              end
              if (last_beat) begin
                state_q <= FINISH;
              end else if (rw_q) begin
                rd_addr_q <= addr_d;
                rdp1_q    <= 1'b1;
              end
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          FINISH: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
            rdp2_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ifc_ad_out = ad_out_q;
  assign ifc_ad_oe  = oe_q;
  assign rd_addr    = rd_addr_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/ifc_burst_xfer.md
Name: ifc_burst_xfer

Overview:
- Downstream data stage of the IFC burst timer.
- Consumes the timer's per-beat strobe (rw_burst_flag) and beat count (cnt).
- Moves one DATA_W word per beat between the IFC AD bus and a local synchronous register file: read bursts drive the AD bus, write bursts capture it.
- Reports completion, timeout and protocol errors to the IFC command decoder, which also pulses the timer's en.

Parameters:
- DATA_W, 16, IFC AD bus / register word width.
- ADDR_W, 8, register file address width; burst address wraps modulo 2^ADDR_W.
- BURST_LEN, 3, beats per burst; must match the timer's beat count.
- TIMEOUT, 64, max clk cycles allowed between command and first beat, and between consecutive beats.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  one-cycle burst start pulse, same cycle as timer en
- cmd_rw  in  1  1 = read (block drives AD), 0 = write (block captures AD); sampled with cmd_valid
- cmd_addr  in  ADDR_W  burst start address, sampled with cmd_valid
- beat_strobe  in  1  timer rw_burst_flag
- beat_cnt  in  8  timer cnt
- ifc_ad_in  in  DATA_W  AD bus input
- ifc_ad_out  out  DATA_W  AD bus drive value
- ifc_ad_oe  out  1  AD bus output enable
- rd_addr  out  ADDR_W  register file read address
- rd_data  in  DATA_W  register file read data, valid 1 cycle after rd_addr
- wr_en  out  1  register file write strobe
- wr_addr  out  ADDR_W  register file write address
- wr_data  out  DATA_W  register file write data
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on timeout or protocol error

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All outputs registered.
- Reset values: all outputs 0; state IDLE; internal addr, beat counter and timeout counter 0.
- States: IDLE, PREFETCH, BEAT, FINISH.
- IDLE:
  - cmd_valid=1 latches addr=cmd_addr, rw=cmd_rw, clears beat counter and timeout counter, sets busy=1.
  - Next state is PREFETCH if read, BEAT if write.
  - beat_strobe in IDLE is ignored.
- PREFETCH (read only, 2 cycles):
  - Cycle 1: rd_addr=addr.
  - Cycle 2: ifc_ad_out<=rd_data, ifc_ad_oe<=1; go to BEAT.
  - beat_strobe during PREFETCH: err pulse, abort to IDLE.
- BEAT, on beat_strobe:
  - Write: next cycle wr_en=1, wr_addr=addr, wr_data=ifc_ad_in as sampled in the strobe cycle.
  - Read: the word on ifc_ad_out is consumed; rd_addr<=addr+1, and ifc_ad_out<=rd_data 2 cycles after the strobe.
  - Both directions: addr<=addr+1 (wraps 2^ADDR_W-1 -> 0), beat counter +1, timeout counter cleared.
- Last beat: on the strobe where the beat counter reaches BURST_LEN, go to FINISH. The write for that beat still issues; no further read prefetch is issued.
- FINISH (1 cycle): done=1, busy<=0, ifc_ad_oe<=0, then IDLE.
- Timeout: in PREFETCH/BEAT the timeout counter increments each cycle without a strobe. At TIMEOUT-1, err=1 for one cycle, oe<=0, busy<=0, go to IDLE; no write is issued.
- cmd_valid while busy is ignored; no queueing.
- done and err never assert in the same cycle.
- Reset mid-burst immediately drops oe, wr_en and busy; no partial write completes.

Optional Feature:
- IFC_BEAT_CHECK_EN defined:
  - On each beat_strobe in BEAT, beat_cnt must equal the internal beat counter +1. The timer updates cnt in the same cycle as the flag.
  - On mismatch: err pulse, abort to IDLE; the write for that beat is suppressed.
- Not defined: beat_cnt is ignored and the port stays present, unused.

Test Plan:
- Write burst: cmd_valid, rw=0, addr=0x10; strobes every 4 cycles with AD=0x1111, 0x2222, 0x3333 -> wr_en x3 at 0x10/0x11/0x12 with those data, done 1 cycle after the last write, busy low after.
- Read burst: regfile[0x20..0x22]=0xA0A0, 0xB1B1, 0xC2C2; cmd rw=1, addr=0x20 -> oe=1 with ifc_ad_out=0xA0A0 before the first strobe, then 0xB1B1 and 0xC2C2 after successive strobes, done then oe=0.
- Wrap: write burst at addr=0xFE -> writes to 0xFE, 0xFF, 0x00.
- Timeout: cmd_valid, rw=0, no strobe for 64 cycles -> err pulse at cycle 64, no wr_en, busy=0; next cmd accepted normally.
- Ignored inputs: second cmd_valid mid-burst and a strobe while IDLE -> no state change, addr unchanged, burst completes normally.
- With IFC_BEAT_CHECK_EN: second strobe arrives with beat_cnt=3 -> err, only 1 write, done never asserts; without the macro -> normal 3-beat completion.
